seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//  Iterative unsigned divider, the inverse of the team's pipelined multiplier datapath.
//  Computes quotient and remainder one quotient bit per clock with a restoring shift-subtract loop.
//  Sits beside the multiplier in the arithmetic library.
//  Valid/ready on both sides, so it can be placed between streaming stages.
// PARAMETERS
//  WN  36  dividend and quotient width in bits.
//  WD  18  divisor and remainder width in bits; WD <= WN is required.
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   synchronous reset, active-high
//  in_valid     in   1   dividend/divisor present
//  in_ready     out  1   block can accept an operand pair
//  dividend     in   WN  unsigned dividend
//  divisor      in   WD  unsigned divisor
//  out_valid    out  1   result present
//  out_ready    in   1   downstream accepts result
//  quotient     out  WN  unsigned quotient
//  remainder    out  WD  unsigned remainder
//  div_by_zero  out  1   result came from a zero divisor
// BEHAVIOUR
//  - Clock is clk; reset rst is synchronous and active-high. All state changes happen on the rising edge of clk.
//  - Reset values:
//    - in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
//    - FSM returns to IDLE. Applies mid-operation too: the in-flight divide is discarded and no result is emitted.
//  - FSM states IDLE, CALC, DONE:
//    - in_ready = (state==IDLE). out_valid = (state==DONE).
//    - IDLE: on in_valid && in_ready, latch dividend and divisor and clear the partial remainder.
//      - divisor!=0: go to CALC with bit counter = WN-1.
//      - divisor==0: go directly to DONE.
//    - CALC: one iteration per cycle, MSB first.
//      - r' = {r, q_msb}. If r' >= divisor: r = r' - divisor, quotient bit = 1; else r = r', bit = 0.
//      - The partial remainder register is WD+1 bits so the compare cannot overflow.
//      - On the edge where counter==0, go to DONE.
//    - DONE: quotient, remainder and div_by_zero are held stable while out_valid && !out_ready.
//      - On out_ready, go to IDLE (out_valid drops, in_ready rises the next cycle).
//  - Latency:
//    - divisor!=0: out_valid is high WN+1 cycles after the accept edge (1 load cycle + WN iterations).
//    - divisor==0: 1 cycle after the accept edge.
//  - Throughput: at most one operation per WN+2 cycles. No new operand is accepted while in CALC or DONE.
//  - Divide by zero: quotient = all ones, remainder = dividend[WD-1:0], div_by_zero = 1.
//  - div_by_zero is 0 for every other result.
//  - Result registers are updated only on entry to DONE; they keep the last result after leaving DONE.
//  - in_valid or operand changes while busy are ignored, with no effect on the current operation.
//  - Invariant for every non-zero divisor: dividend == quotient*divisor + remainder, and remainder < divisor.
// TESTING
//  - 1000/7 -> out_valid 37 cycles after accept; quotient=142, remainder=6, div_by_zero=0.
//  - 0xF_FFFF_FFFF/1 -> quotient=0xF_FFFF_FFFF, remainder=0.
//  - 3/0x3FFFF -> quotient=0, remainder=3.
//  - 5/0 -> out_valid 1 cycle after accept; quotient=0xF_FFFF_FFFF, remainder=5, div_by_zero=1.
//  - Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout.
//    Then assert out_ready=1 -> next cycle in_ready=1; a back-to-back second op 100/10 gives quotient=10, remainder=0.
//  - Reset mid-operation:
//    - Assert rst 10 cycles into 1000/7 -> next cycle in_ready=1, out_valid=0, outputs all zero.
//    - Then issue 9/4 -> quotient=2, remainder=1.
//  - Random sweep: 10k random operand pairs checked against the invariant and a reference model.

Source files
------------

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first.
// Valid/ready handshakes on operand and result sides; results are held in DONE until taken.
module seq_divider #(
    parameter int WN = 36,
    parameter int WD = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WN-1:0] dividend,
    input  logic [WD-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WN-1:0] quotient,
    output logic [WD-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = (WN > 1) ? $clog2(WN) : 1;
    localparam logic [CW-1:0] CNT_LAST  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_START = CW'(WN - 1);
    localparam logic [CW-1:0] CNT_STEP  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [WD-1:0] r_divisor;
    logic [WN-1:0] r_work;
    logic [WD:0]   r_rem;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [WN-1:0] r_quotient;
    logic [WD-1:0] r_remainder;
    logic          r_dbz;

    logic [WD+1:0] w_shift;
    logic [WD:0]   w_div_ext;
    logic          w_ge;
    logic [WD:0]   w_diff;
    logic [WD:0]   w_rem_next;
    logic [WN-1:0] w_work_next;
    logic          w_div_zero;

    // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
    // r_work doubles as the dividend shifter and the quotient accumulator.
    assign w_shift     = {r_rem, r_work[WN-1]};
    assign w_div_ext   = {1'b0, r_divisor};
    assign w_ge        = (w_shift >= {1'b0, w_div_ext});
    assign w_diff      = w_shift[WD:0] - w_div_ext;
    assign w_rem_next  = w_ge ? w_diff : w_shift[WD:0];
    assign w_work_next = {r_work[WN-2:0], w_ge};
    assign w_div_zero  = (divisor == {WD{1'b0}});

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

    // Control FSM, iteration datapath and registered result/handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= CNT_LAST;
            r_divisor   <= {WD{1'b0}};
            r_work      <= {WN{1'b0}};
            r_rem       <= {(WD+1){1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quotient  <= {WN{1'b0}};
            r_remainder <= {WD{1'b0}};
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_divisor  <= divisor;
                        r_work     <= dividend;
                        r_rem      <= {(WD+1){1'b0}};
                        r_in_ready <= 1'b0;
                        if (w_div_zero) begin
                            // Zero divisor skips the loop and reports a saturated quotient.
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_quotient  <= {WN{1'b1}};
                            r_remainder <= dividend[WD-1:0];
                            r_dbz       <= 1'b1;
                        end else begin
                            r_state <= S_CALC;
                            r_cnt   <= CNT_START;
                        end
                    end
                end
                S_CALC: begin
                    r_work <= w_work_next;
                    r_rem  <= w_rem_next;
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_quotient  <= w_work_next;
                        r_remainder <= w_rem_next[WD-1:0];
                        r_dbz       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_STEP;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
